// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side drain engine with 3-entry skid buffer and valid/ready output.
// Optional word counter port rd_count enabled by defining FIFO_READER_STATS_EN.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic                  push, pop;

    always_comb begin
        fifo_rd_en = 1'b0;
        m_valid    = (state_q != ST_EMPTY);
        m_data     = buf_q[head_q];
        push       = inflight_q;
        pop        = m_valid && m_ready;
        // Credit counts the word already in flight so a capture never lands on a full buffer.
        if (!rst && !fifo_empty && (({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3)) begin
            fifo_rd_en = 1'b1;
        end
        inflight_d = fifo_rd_en;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        head_d     = head_q;
        tail_d     = tail_q;
        if (pop) begin
            head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
        end
        if (push) begin
            tail_d = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
        end
        state_d = ST_PARTIAL;
        if (occ_d == 2'd0) begin
            state_d = ST_EMPTY;
        end else if (occ_d == 2'd3) begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                buf_q[tail_q] <= fifo_data_out;
            end
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_WIDTH-1:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 1'b1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader with a behavioural FIFO and scoreboard.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_READER_STATS_EN
    logic [CW-1:0] rd_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data)
`ifdef FIFO_READER_STATS_EN
        ,
        .rd_count      (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: writes come from the stimulus, reads have one cycle of latency.
    logic [DW-1:0] mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          fifo_flush;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data_out <= mem[rd_ptr % 4096];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Stream recorder: accepted words, read-request count, and hold-while-stalled violations.
    logic [DW-1:0] got [$];
    int            rd_en_cnt  = 0;
    int            stall_viol = 0;
    logic          stall_prev = 1'b0;
    logic          rst_prev   = 1'b1;
    logic [DW-1:0] data_prev  = '0;

    always @(negedge clk) begin
        if (fifo_rd_en) rd_en_cnt++;
        if (stall_prev && !rst_prev && (!m_valid || m_data !== data_prev)) stall_viol++;
        if (!rst && m_valid && m_ready) got.push_back(m_data);
        stall_prev = m_valid && !m_ready && !rst;
        data_prev  = m_data;
        rst_prev   = rst;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr % 4096] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fifo_flush = 1'b0; m_ready = 1'b0;
        push_word(8'h5A);
        push_word(8'hC3);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: rd_en=%b valid=%b data=%h, required 0 0 00",
                         c, fifo_rd_en, m_valid, m_data);
            end
        end
        fifo_flush = 1'b1;
        tick();
        rst = 1'b0; fifo_flush = 1'b0;
    endtask

    task automatic test_latency();
        logic [DW-1:0] w [4];
        int k;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        m_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_word(w[i]);
        @(negedge clk);
        n_tests++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_rd_en: rd_en=%b, required 1 in cycle FIFO goes non-empty", fifo_rd_en);
        end
        k = 0;
        while (m_valid !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL latency_valid: m_valid after %0d cycles, required 2", k);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== w[i]) begin
                n_fail++;
                $display("FAIL latency_word%0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, w[i]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_drained: m_valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [8];
        int base;
        m_ready = 1'b0;
        tick();
        base = rd_en_cnt;
        for (int i = 0; i < 8; i++) begin
            w[i] = DW'($urandom);
            push_word(w[i]);
        end
        repeat (10) tick();
        @(negedge clk);
        n_tests++;
        if (rd_en_cnt - base != 3 || fifo_rd_en !== 1'b0 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill: rd_en pulses=%0d rd_en=%b valid=%b, required 3 0 1",
                     rd_en_cnt - base, fifo_rd_en, m_valid);
        end
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== w[i]) begin
                n_fail++;
                $display("FAIL bp_drain_word%0d: valid=%b data=%h, required 1 %h", i, m_valid, m_data, w[i]);
            end
        end
    endtask

    task automatic test_toggle();
        int base;
        m_ready = 1'b1;
        tick();
        base = got.size();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        for (int c = 0; c < 60; c++) begin
            tick();
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (got.size() - base != 16) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d words, required 16", got.size() - base);
        end
        for (int i = 0; i < 16 && base + i < got.size(); i++) begin
            n_tests++;
            if (got[base + i] !== DW'(i)) begin
                n_fail++;
                $display("FAIL toggle_word%0d: got %h, required %h", i, got[base + i], DW'(i));
            end
        end
        n_tests++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL toggle_hold: %0d stalled-word changes, required 0", stall_viol);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] sent [$];
        int base, k;
        base = got.size();
        for (int c = 0; c < 300; c++) begin
            tick();
            if ($urandom_range(0, 2) != 0) begin
                sent.push_back(DW'($urandom));
                push_word(sent[sent.size() - 1]);
            end
            m_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        m_ready = 1'b1;
        k = 0;
        while (got.size() - base < sent.size() && k < 400) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_tests++;
        if (got.size() - base != sent.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d words, required %0d", got.size() - base, sent.size());
        end
        for (int i = 0; i < sent.size() && base + i < got.size(); i++) begin
            n_tests++;
            if (got[base + i] !== sent[i]) begin
                n_fail++;
                $display("FAIL random_word%0d: got %h, required %h", i, got[base + i], sent[i]);
            end
        end
        n_tests++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL random_hold: %0d stalled-word changes, required 0", stall_viol);
        end
    endtask

    task automatic test_reset_mid();
        int base, k;
        m_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_word(8'h60 + DW'(i));
        @(negedge clk);
        n_tests++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_issue: rd_en=%b, required 1", fifo_rd_en);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h60) begin
            n_fail++;
            $display("FAIL rstmid_prefill: valid=%b data=%h, required 1 60", m_valid, m_data);
        end
        tick();
        rst = 1'b1; fifo_flush = 1'b1;
        tick();
        rst = 1'b0; fifo_flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: valid=%b rd_en=%b, required 0 0", m_valid, fifo_rd_en);
        end
        repeat (3) tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_ghost: valid=%b, required 0", m_valid);
        end
        base = got.size();
        push_word(8'hA5);
        m_ready = 1'b1;
        k = 0;
        while (got.size() == base && k < 10) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_tests++;
        if (got.size() - base != 1 || got[base] !== 8'hA5) begin
            n_fail++;
            $display("FAIL rstmid_refill: %0d words, first %h, required 1 word a5",
                     got.size() - base, (got.size() > base) ? got[base] : 8'hxx);
        end
    endtask

`ifdef FIFO_READER_STATS_EN
    task automatic test_stats();
        int base, k;
        tick();
        rst = 1'b1; fifo_flush = 1'b1;
        tick();
        rst = 1'b0; fifo_flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd_count !== 8'd0) begin
            n_fail++;
            $display("FAIL stats_reset: rd_count=%0d, required 0", rd_count);
        end
        tick();
        base = got.size();
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_word(DW'($urandom));
        k = 0;
        while (got.size() - base < 300 && k < 500) begin
            tick();
            k++;
        end
        repeat (3) tick();
        n_tests++;
        if (rd_count !== 8'(300 % 256)) begin
            n_fail++;
            $display("FAIL stats_wrap: rd_count=%0d, required %0d", rd_count, 300 % 256);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; fifo_flush = 1'b0; m_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_toggle();
        test_random();
        test_reset_mid();
`ifdef FIFO_READER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
